// File: rtl/global_pool_v2.sv
// Global average/max pooling stage: accumulates a channel-interleaved feature map in RAM,
// then streams one rounded-average or maximum result per channel over valid/ready.
module global_pool_v2 #(
  parameter int unsigned WIDTH_D = 27,
  parameter int unsigned CH      = 512,
  parameter int unsigned HW      = 49,
  parameter int unsigned WIDTH_S = WIDTH_D + $clog2(HW)
) (
  input  logic               i_sclk,
  input  logic               i_rstn,
  input  logic               i_vsync,
  input  logic               i_mode,
  input  logic               i_valid,
  input  logic [WIDTH_D-1:0] i_tdata,
  output logic               o_in_ready,
  output logic               o_valid,
  input  logic               i_out_ready,
  output logic [WIDTH_D-1:0] o_tdata,
  output logic               o_last,
  output logic               o_done
);

  localparam int unsigned ChW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned PxW  = $clog2(HW);
  localparam int unsigned CntW = $clog2(WIDTH_S + 1);

  localparam logic [ChW-1:0]   ChLast  = ChW'(CH - 1);
  localparam logic [PxW-1:0]   PxLast  = PxW'(HW - 1);
  localparam logic [CntW-1:0]  DivLast = CntW'(WIDTH_S - 1);
  localparam logic [WIDTH_S:0] HwW     = (WIDTH_S + 1)'(HW);
  localparam logic [WIDTH_S:0] HalfW   = (WIDTH_S + 1)'(HW >> 1);

  typedef enum logic [1:0] {StIdle, StAccum, StFlush, StOut} state_e;
  typedef enum logic [2:0] {PhRead, PhLoad, PhDiv, PhRound, PhHold} phase_e;

  state_e                    state_q;
  phase_e                    phase_q;
  logic                      mode_q;
  logic [ChW-1:0]            ch_q;
  logic [PxW-1:0]            px_q;
  logic                      flush_q;

  logic                      s1_vld_q;
  logic [ChW-1:0]            s1_addr_q;
  logic signed [WIDTH_S-1:0] s1_data_q;
  logic                      s1_first_q;

  logic signed [WIDTH_S-1:0] mem_q [CH];
  logic signed [WIDTH_S-1:0] rd_q;

  logic                      neg_q;
  logic [WIDTH_S-1:0]        quo_q;
  logic [WIDTH_S:0]          rem_q;
  logic [CntW-1:0]           div_cnt_q;

  logic                      o_valid_q;
  logic [WIDTH_D-1:0]        o_tdata_q;
  logic                      o_last_q;
  logic                      o_done_q;

  logic                      accept;
  logic                      rd_en;
  logic signed [WIDTH_S-1:0] sample_ext;
  logic signed [WIDTH_S-1:0] acc_d;
  logic [WIDTH_S:0]          rem_sh;
  logic                      div_ge;
  logic                      round_up;
  logic [WIDTH_D-1:0]        mag_d;

  assign accept     = (state_q == StAccum) && i_valid && !i_vsync;
  assign rd_en      = accept || ((state_q == StOut) && (phase_q == PhRead));
  assign sample_ext = {{(WIDTH_S - WIDTH_D){i_tdata[WIDTH_D-1]}}, i_tdata};

  // Second half of the read-modify-write; the read was issued when the sample was accepted.
  always_comb begin
    acc_d = s1_data_q;
    if (!s1_first_q) begin
      if (mode_q) acc_d = (s1_data_q > rd_q) ? s1_data_q : rd_q;
      else        acc_d = rd_q + s1_data_q;
    end
  end

  // One restoring-division step of |S| by HW, plus final rounding.
  always_comb begin
    rem_sh   = {rem_q[WIDTH_S-1:0], quo_q[WIDTH_S-1]};
    div_ge   = (rem_sh >= HwW);
    round_up = (rem_q > HalfW);
    mag_d    = quo_q[WIDTH_D-1:0] + WIDTH_D'(round_up);
  end

  always_ff @(posedge i_sclk) begin
    if (s1_vld_q) mem_q[s1_addr_q] <= acc_d;
    if (rd_en)    rd_q <= mem_q[ch_q];
  end

  always_ff @(posedge i_sclk) begin
    o_done_q <= 1'b0;
    s1_vld_q <= 1'b0;
    if (!i_rstn) begin
      state_q    <= StIdle;
      phase_q    <= PhRead;
      mode_q     <= 1'b0;
      ch_q       <= '0;
      px_q       <= '0;
      flush_q    <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s1_first_q <= 1'b0;
      neg_q      <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      div_cnt_q  <= '0;
      o_valid_q  <= 1'b0;
      o_tdata_q  <= '0;
      o_last_q   <= 1'b0;
    end else if (i_vsync) begin
      state_q   <= StAccum;
      phase_q   <= PhRead;
      mode_q    <= i_mode;
      ch_q      <= '0;
      px_q      <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAccum: begin
          if (i_valid) begin
            s1_vld_q   <= 1'b1;
            s1_addr_q  <= ch_q;
            s1_data_q  <= sample_ext;
            s1_first_q <= (px_q == '0);
            if (ch_q == ChLast) begin
              ch_q <= '0;
              if (px_q == PxLast) begin
                state_q <= StFlush;
                flush_q <= 1'b0;
              end else begin
                px_q <= px_q + PxW'(1);
              end
            end else begin
              ch_q <= ch_q + ChW'(1);
            end
          end
        end
        StFlush: begin
          // Two cycles let the final RAM write land before the first readback.
          flush_q <= 1'b1;
          if (flush_q) begin
            state_q <= StOut;
            phase_q <= PhRead;
            ch_q    <= '0;
          end
        end
        StOut: begin
          unique case (phase_q)
            PhRead: phase_q <= PhLoad;
            PhLoad: begin
              neg_q     <= rd_q[WIDTH_S-1];
              quo_q     <= rd_q[WIDTH_S-1] ? -rd_q : rd_q;
              rem_q     <= '0;
              div_cnt_q <= '0;
              if (mode_q) begin
                o_tdata_q <= rd_q[WIDTH_D-1:0];
                o_valid_q <= 1'b1;
                o_last_q  <= (ch_q == ChLast);
                phase_q   <= PhHold;
              end else begin
                phase_q <= PhDiv;
              end
            end
            PhDiv: begin
              rem_q     <= div_ge ? (rem_sh - HwW) : rem_sh;
              quo_q     <= {quo_q[WIDTH_S-2:0], div_ge};
              div_cnt_q <= div_cnt_q + CntW'(1);
              if (div_cnt_q == DivLast) phase_q <= PhRound;
            end
            PhRound: begin
              o_tdata_q <= neg_q ? -mag_d : mag_d;
              o_valid_q <= 1'b1;
              o_last_q  <= (ch_q == ChLast);
              phase_q   <= PhHold;
            end
            PhHold: begin
              if (i_out_ready) begin
                o_valid_q <= 1'b0;
                o_last_q  <= 1'b0;
                if (ch_q == ChLast) begin
                  state_q  <= StIdle;
                  o_done_q <= 1'b1;
                end else begin
                  ch_q    <= ch_q + ChW'(1);
                  phase_q <= PhRead;
                end
              end
            end
            default: phase_q <= PhRead;
          endcase
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_in_ready = (state_q == StAccum);
  assign o_valid    = o_valid_q;
  assign o_tdata    = o_tdata_q;
  assign o_last     = o_last_q;
  assign o_done     = o_done_q;

endmodule

// File: tb/tb_global_pool_v2.sv
// Directed bench for global_pool_v2 with CH=4, HW=49: averaging, rounding, max,
// backpressure, frame abort and mid-output reset.
module tb_global_pool_v2;

  localparam int WD = 27;
  localparam int CH = 4;
  localparam int HW = 49;

  logic          clk = 1'b0;
  logic          i_rstn, i_vsync, i_mode, i_valid, i_out_ready;
  logic [WD-1:0] i_tdata;
  logic          o_in_ready, o_valid, o_last, o_done;
  logic signed [WD-1:0] o_tdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [WD-1:0] res_q[$];
  logic                 last_q[$];
  logic                 done_after, done_after2, valid_after;
  int                   hold_err, early_done;
  bit                   timeout_f;

  always #5 clk = ~clk;

  global_pool_v2 #(.WIDTH_D(WD), .CH(CH), .HW(HW)) dut (
    .i_sclk      (clk),
    .i_rstn      (i_rstn),
    .i_vsync     (i_vsync),
    .i_mode      (i_mode),
    .i_valid     (i_valid),
    .i_tdata     (i_tdata),
    .o_in_ready  (o_in_ready),
    .o_valid     (o_valid),
    .i_out_ready (i_out_ready),
    .o_tdata     (o_tdata),
    .o_last      (o_last),
    .o_done      (o_done)
  );

  function automatic int sample_val(int pat, int cval, int px, int ch);
    case (pat)
      1: case (ch)
           0:       return (px == 48) ? 24 : 0;
           1:       return (px == 0) ? 25 : 0;
           2:       return (px == 10) ? -25 : 0;
           default: return (px < 45) ? 6 : 0;
         endcase
      2: case (ch)
           0:       return (px == 30) ? 7 : -5;
           1:       return -8;
           2:       return (px == 0) ? 67108863 : -1;
           default: return -67108864;
         endcase
      3: case (ch)
           0:       return 10;
           1:       return -7;
           2:       return 0;
           default: return 100;
         endcase
      default: return cval;
    endcase
  endfunction

  // vsync, then npx pixels; i_mode is flipped after vsync to show it is ignored mid-frame.
  task automatic send_frame(input logic mode, input int pat, input int cval, input int npx,
                            input bit gaps);
    int k = 0;
    @(negedge clk);
    i_vsync = 1'b1; i_mode = mode; i_valid = 1'b0;
    @(negedge clk);
    i_vsync = 1'b0; i_mode = ~mode;
    for (int px = 0; px < npx; px++) begin
      for (int ch = 0; ch < CH; ch++) begin
        if (gaps && (k % 7 == 3)) begin
          i_valid = 1'b0;
          @(negedge clk);
        end
        i_valid = 1'b1;
        i_tdata = WD'(sample_val(pat, cval, px, ch));
        @(negedge clk);
        k++;
      end
    end
    i_valid = 1'b0;
  endtask

  // Records every transfer until the o_last one; bp selects a 1,0,0 ready pattern.
  task automatic collect(input bit bp, input int budget);
    int            cyc = 0;
    bit            got_last = 0;
    bit            have_hold = 0;
    logic [WD-1:0] hold_v = '0;
    logic          hold_l = 1'b0;
    logic          rdy;
    res_q.delete(); last_q.delete();
    hold_err = 0; early_done = 0; timeout_f = 0;
    forever begin
      @(negedge clk);
      if (have_hold && (o_valid !== 1'b1 || o_tdata !== hold_v || o_last !== hold_l)) hold_err++;
      if (got_last) break;
      if (o_done) early_done++;
      if (cyc >= budget) begin
        timeout_f = 1;
        break;
      end
      rdy = bp ? (cyc % 3 == 0) : 1'b1;
      i_out_ready = rdy;
      have_hold = o_valid && !rdy;
      hold_v = o_tdata;
      hold_l = o_last;
      if (o_valid && rdy) begin
        res_q.push_back(o_tdata);
        last_q.push_back(o_last);
        if (o_last) got_last = 1;
      end
      cyc++;
    end
    i_out_ready = 1'b0;
    done_after  = o_done;
    valid_after = o_valid;
    @(negedge clk);
    done_after2 = o_done;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_vsync = 1'b1; i_mode = 1'b0; i_valid = 1'b0;
    i_tdata = '0; i_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({o_in_ready, o_valid, o_last, o_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 0000", {o_in_ready, o_valid, o_last, o_done});
    end
    n_tests++;
    if (o_tdata !== '0) begin
      n_fail++;
      $display("FAIL reset_tdata got %0d exp 0", o_tdata);
    end
    i_rstn = 1'b1; i_vsync = 1'b0;
    @(negedge clk);
    n_tests++;
    if (o_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_over_vsync in_ready got %b exp 0", o_in_ready);
    end
  endtask

  task automatic test_avg_const();
    logic signed [WD-1:0] g;
    logic [CH-1:0]        lv = '0;
    send_frame(1'b0, 0, 3, HW, 1'b0);
    collect(1'b0, 2000);
    n_tests++;
    if (res_q.size() != CH || timeout_f) begin
      n_fail++;
      $display("FAIL t1_count got %0d exp %0d (timeout %0d)", res_q.size(), CH, timeout_f);
    end
    for (int i = 0; i < CH; i++) begin
      g = (i < res_q.size()) ? res_q[i] : 'x;
      if (i < last_q.size()) lv[i] = last_q[i];
      n_tests++;
      if (g !== WD'(3)) begin
        n_fail++;
        $display("FAIL t1_out[%0d] got %0d exp 3", i, g);
      end
    end
    n_tests++;
    if (lv !== 4'b1000) begin
      n_fail++;
      $display("FAIL t1_last got %b exp 1000", lv);
    end
    n_tests++;
    if ({done_after, done_after2, valid_after, early_done != 0} !== 4'b1000) begin
      n_fail++;
      $display("FAIL t1_done got done=%b next=%b valid=%b early=%0d exp 1,0,0,0",
               done_after, done_after2, valid_after, early_done);
    end
  endtask

  task automatic test_rounding();
    int                   exp_v[CH] = '{0, 1, -1, 6};
    logic signed [WD-1:0] g;
    send_frame(1'b0, 1, 0, HW, 1'b1);
    collect(1'b0, 2000);
    n_tests++;
    if (res_q.size() != CH || timeout_f) begin
      n_fail++;
      $display("FAIL t2_count got %0d exp %0d", res_q.size(), CH);
    end
    for (int i = 0; i < CH; i++) begin
      g = (i < res_q.size()) ? res_q[i] : 'x;
      n_tests++;
      if (g !== WD'(exp_v[i])) begin
        n_fail++;
        $display("FAIL t2_round[%0d] got %0d exp %0d", i, g, exp_v[i]);
      end
    end
  endtask

  task automatic test_max();
    int                   exp_v[CH] = '{7, -8, 67108863, -67108864};
    logic signed [WD-1:0] g;
    send_frame(1'b1, 2, 0, HW, 1'b0);
    collect(1'b0, 2000);
    n_tests++;
    if (res_q.size() != CH || timeout_f) begin
      n_fail++;
      $display("FAIL t3_count got %0d exp %0d", res_q.size(), CH);
    end
    for (int i = 0; i < CH; i++) begin
      g = (i < res_q.size()) ? res_q[i] : 'x;
      n_tests++;
      if (g !== WD'(exp_v[i])) begin
        n_fail++;
        $display("FAIL t3_max[%0d] got %0d exp %0d", i, g, exp_v[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int                   exp_v[CH] = '{10, -7, 0, 100};
    logic signed [WD-1:0] g;
    send_frame(1'b0, 3, 0, HW, 1'b0);
    collect(1'b1, 3000);
    n_tests++;
    if (res_q.size() != CH || timeout_f) begin
      n_fail++;
      $display("FAIL t4_count got %0d exp %0d", res_q.size(), CH);
    end
    n_tests++;
    if (hold_err != 0) begin
      n_fail++;
      $display("FAIL t4_hold_stable got %0d violations exp 0", hold_err);
    end
    for (int i = 0; i < CH; i++) begin
      g = (i < res_q.size()) ? res_q[i] : 'x;
      n_tests++;
      if (g !== WD'(exp_v[i])) begin
        n_fail++;
        $display("FAIL t4_out[%0d] got %0d exp %0d", i, g, exp_v[i]);
      end
    end
    n_tests++;
    if (done_after !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_done got %b exp 1", done_after);
    end
  endtask

  task automatic test_abort();
    logic signed [WD-1:0] g;
    send_frame(1'b0, 0, 9, 10, 1'b0);
    send_frame(1'b0, 0, 2, HW, 1'b0);
    i_valid = 1'b1;
    i_tdata = WD'(1000);
    n_tests++;
    if (o_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_in_ready_after_frame got %b exp 0", o_in_ready);
    end
    collect(1'b0, 2000);
    i_valid = 1'b0;
    n_tests++;
    if (res_q.size() != CH || timeout_f) begin
      n_fail++;
      $display("FAIL t5_count got %0d exp %0d", res_q.size(), CH);
    end
    for (int i = 0; i < CH; i++) begin
      g = (i < res_q.size()) ? res_q[i] : 'x;
      n_tests++;
      if (g !== WD'(2)) begin
        n_fail++;
        $display("FAIL t5_out[%0d] got %0d exp 2", i, g);
      end
    end
  endtask

  task automatic test_reset_mid_out();
    int                   xf = 0;
    int                   cyc = 0;
    logic signed [WD-1:0] g;
    send_frame(1'b0, 0, 5, HW, 1'b0);
    i_out_ready = 1'b1;
    while (xf < 2 && cyc < 1000) begin
      @(negedge clk);
      if (o_valid) xf++;
      cyc++;
    end
    n_tests++;
    if (xf != 2) begin
      n_fail++;
      $display("FAIL t6_pre_transfers got %0d exp 2", xf);
    end
    @(negedge clk);
    i_out_ready = 1'b0;
    i_rstn = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({o_valid, o_last, o_in_ready} !== 3'b000 || o_tdata !== '0) begin
      n_fail++;
      $display("FAIL t6_after_reset got valid=%b last=%b in_ready=%b tdata=%0d exp 0,0,0,0",
               o_valid, o_last, o_in_ready, o_tdata);
    end
    i_rstn = 1'b1;
    repeat (50) @(negedge clk);
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_idle_valid got %b exp 0", o_valid);
    end
    send_frame(1'b0, 0, 1, HW, 1'b0);
    collect(1'b0, 2000);
    n_tests++;
    if (res_q.size() != CH || timeout_f) begin
      n_fail++;
      $display("FAIL t6_count got %0d exp %0d", res_q.size(), CH);
    end
    for (int i = 0; i < CH; i++) begin
      g = (i < res_q.size()) ? res_q[i] : 'x;
      n_tests++;
      if (g !== WD'(1)) begin
        n_fail++;
        $display("FAIL t6_out[%0d] got %0d exp 1", i, g);
      end
    end
  endtask

  initial begin
    test_reset();
    test_avg_const();
    test_rounding();
    test_max();
    test_backpressure();
    test_abort();
    test_reset_mid_out();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
